// File: rtl/reg_cmd_ctrl_if.sv
// Signal bundle between reg_cmd_ctrl and its UART RX/TX and register-file neighbours.
// master = command controller; slave = surrounding datapath (RX deserializer, register file, TX serializer).
interface reg_cmd_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic [DATA_WIDTH-1:0] RX_P_DATA;
  logic                  RX_D_VLD;
  logic [ADDR_WIDTH-1:0] Address;
  logic                  WrEn;
  logic                  RdEn;
  logic [DATA_WIDTH-1:0] WrData;
  logic [DATA_WIDTH-1:0] RdData;
  logic                  RdData_Valid;
  logic [DATA_WIDTH-1:0] TX_P_DATA;
  logic                  TX_D_VLD;
  logic                  TX_Busy;
  logic                  Cmd_Busy;

  modport master (
    input  RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, TX_Busy,
    output Address, WrEn, RdEn, WrData, TX_P_DATA, TX_D_VLD, Cmd_Busy
  );

  modport slave (
    output RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, TX_Busy,
    input  Address, WrEn, RdEn, WrData, TX_P_DATA, TX_D_VLD, Cmd_Busy
  );
endinterface

// File: rtl/reg_cmd_ctrl.sv
// UART frame parser (0xAA addr data = write, 0xBB addr = read) driving register-file strobes; all outputs registered,
// read data reaches TX two edges after the address byte and is held until TX_Busy=0; REG_CMD_TIMEOUT_EN adds a partial-frame idle timeout.
module reg_cmd_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic            CLK,
  input logic            RST,
  reg_cmd_ctrl_if.master cmd_if
);

  localparam logic [DATA_WIDTH-1:0] CMD_WR = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD = DATA_WIDTH'(8'hBB);

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    TX_SEND
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  wr_en_q, wr_en_d;
  logic                  rd_en_q, rd_en_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_vld_q, tx_vld_d;
  logic                  busy_q, busy_d;

`ifdef REG_CMD_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    tx_data_d = tx_data_q;
    tx_vld_d  = tx_vld_q;

    case (state_q)
      IDLE: begin
        if (cmd_if.RX_D_VLD) begin
          if (cmd_if.RX_P_DATA == CMD_WR)      state_d = WR_ADDR;
          else if (cmd_if.RX_P_DATA == CMD_RD) state_d = RD_ADDR;
        end
      end
      WR_ADDR: begin
        if (cmd_if.RX_D_VLD) begin
          addr_d  = cmd_if.RX_P_DATA[ADDR_WIDTH-1:0];
          state_d = WR_DATA;
        end
      end
      WR_DATA: begin
        if (cmd_if.RX_D_VLD) begin
          wr_data_d = cmd_if.RX_P_DATA;
          wr_en_d   = 1'b1;
          state_d   = IDLE;
        end
      end
      RD_ADDR: begin
        if (cmd_if.RX_D_VLD) begin
          addr_d  = cmd_if.RX_P_DATA[ADDR_WIDTH-1:0];
          rd_en_d = 1'b1;
          state_d = RD_WAIT;
        end
      end
      // RX bytes are deliberately ignored in both busy states.
      RD_WAIT: begin
        if (cmd_if.RdData_Valid) begin
          tx_data_d = cmd_if.RdData;
          tx_vld_d  = 1'b1;
          state_d   = TX_SEND;
        end
      end
      TX_SEND: begin
        if (!cmd_if.TX_Busy) begin
          tx_vld_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef REG_CMD_TIMEOUT_EN
    // Counter idles at zero outside the parse states, so every parse-state entry starts from zero.
    tmo_cnt_d = '0;
    if ((state_q == WR_ADDR || state_q == WR_DATA || state_q == RD_ADDR) && !cmd_if.RX_D_VLD) begin
      if (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) state_d = IDLE;
      else                                         tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
    end
`endif

    busy_d = (state_d == RD_WAIT) || (state_d == TX_SEND);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      wr_data_q <= '0;
      tx_data_q <= '0;
      tx_vld_q  <= 1'b0;
      busy_q    <= 1'b0;
`ifdef REG_CMD_TIMEOUT_EN
      tmo_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      wr_data_q <= wr_data_d;
      tx_data_q <= tx_data_d;
      tx_vld_q  <= tx_vld_d;
      busy_q    <= busy_d;
`ifdef REG_CMD_TIMEOUT_EN
      tmo_cnt_q <= tmo_cnt_d;
`endif
    end
  end

  assign cmd_if.Address   = addr_q;
  assign cmd_if.WrEn      = wr_en_q;
  assign cmd_if.RdEn      = rd_en_q;
  assign cmd_if.WrData    = wr_data_q;
  assign cmd_if.TX_P_DATA = tx_data_q;
  assign cmd_if.TX_D_VLD  = tx_vld_q;
  assign cmd_if.Cmd_Busy  = busy_q;

endmodule

// File: tb/tb_reg_cmd_ctrl.sv
// Bench for reg_cmd_ctrl: directed frames plus a randomized run against a frame-queue reference model.
module tb_reg_cmd_ctrl;

  localparam logic [7:0] AA = 8'hAA;
  localparam logic [7:0] BB = 8'hBB;

  logic CLK;
  logic RST;
  int   vectors;
  int   miscompares;

  reg_cmd_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) cmd_if ();

  reg_cmd_ctrl #(
    .DATA_WIDTH    (8),
    .ADDR_WIDTH    (4),
    .TIMEOUT_CYCLES(20)
  ) dut (
    .CLK   (CLK),
    .RST   (RST),
    .cmd_if(cmd_if)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Observed output vector, field order: Address, WrEn, RdEn, WrData, TX_P_DATA, TX_D_VLD, Cmd_Busy.
  logic [23:0] obs;
  assign obs = {cmd_if.Address, cmd_if.WrEn, cmd_if.RdEn, cmd_if.WrData,
                cmd_if.TX_P_DATA, cmd_if.TX_D_VLD, cmd_if.Cmd_Busy};

  function automatic logic [23:0] ev(input logic [3:0] a, input logic w, input logic r,
                                     input logic [7:0] wd, input logic [7:0] txd,
                                     input logic txv, input logic bsy);
    return {a, w, r, wd, txd, txv, bsy};
  endfunction

  // Register-file stand-in: writes on WrEn, answers RdEn one cycle later with RdData_Valid.
  logic [7:0] rf_mem [16];
  logic       rsp_pend;
  logic [3:0] rsp_addr;

  initial begin
    cmd_if.RdData_Valid = 1'b0;
    cmd_if.RdData       = 8'h00;
    forever begin
      @(negedge CLK);
      rsp_pend = (cmd_if.RdEn === 1'b1);
      rsp_addr = cmd_if.Address;
      if (cmd_if.WrEn === 1'b1) rf_mem[cmd_if.Address] = cmd_if.WrData;
      @(posedge CLK);
      #1;
      cmd_if.RdData_Valid = rsp_pend;
      cmd_if.RdData       = rsp_pend ? rf_mem[rsp_addr] : 8'($urandom);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    cmd_if.RX_P_DATA = b;
    cmd_if.RX_D_VLD  = 1'b1;
    @(posedge CLK);
    #1;
    cmd_if.RX_D_VLD  = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    logic [23:0] e;
    e = ev(4'h0, 0, 0, 8'h00, 8'h00, 0, 0);
    #2;
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL reset_asserted: got %h want %h", obs, e); end
    @(posedge CLK); @(posedge CLK); #1;
    RST = 1'b1;
    tick(1);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL reset_released: got %h want %h", obs, e); end
  endtask

  task automatic test_write;
    logic [23:0] e;
    send_byte(AA);
    send_byte(8'h05);
    e = ev(4'h5, 0, 0, 8'h00, 8'h00, 0, 0);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL write_addr: got %h want %h", obs, e); end
    send_byte(8'h3C);
    e = ev(4'h5, 1, 0, 8'h3C, 8'h00, 0, 0);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL write_strobe: got %h want %h", obs, e); end
    tick(1);
    e = ev(4'h5, 0, 0, 8'h3C, 8'h00, 0, 0);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL write_one_cycle: got %h want %h", obs, e); end
  endtask

  task automatic test_read;
    logic [23:0] e;
    cmd_if.TX_Busy = 1'b1;
    send_byte(BB);
    send_byte(8'h05);
    e = ev(4'h5, 0, 1, 8'h3C, 8'h00, 0, 1);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL read_strobe: got %h want %h", obs, e); end
    tick(1);
    e = ev(4'h5, 0, 0, 8'h3C, 8'h00, 0, 1);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL read_wait: got %h want %h", obs, e); end
    tick(1);
    e = ev(4'h5, 0, 0, 8'h3C, 8'h3C, 1, 1);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL read_capture: got %h want %h", obs, e); end
  endtask

  task automatic test_backpressure;
    logic [23:0] e;
    e = ev(4'h5, 0, 0, 8'h3C, 8'h3C, 1, 1);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL tx_hold[%0d]: got %h want %h", i, obs, e); end
    end
    cmd_if.TX_Busy = 1'b0;
    tick(1);
    e = ev(4'h5, 0, 0, 8'h3C, 8'h3C, 0, 0);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL tx_accept: got %h want %h", obs, e); end
  endtask

  task automatic test_garbage_drop;
    logic [23:0] e;
    send_byte(8'h12);
    tick(1);
    e = ev(4'h5, 0, 0, 8'h3C, 8'h3C, 0, 0);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL garbage_ignored: got %h want %h", obs, e); end
    cmd_if.TX_Busy = 1'b1;
    send_byte(BB);
    send_byte(8'h01);
    send_byte(AA);
    e = ev(4'h1, 0, 0, 8'h3C, 8'h3C, 0, 1);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL drop_in_wait: got %h want %h", obs, e); end
    tick(1);
    e = ev(4'h1, 0, 0, 8'h3C, rf_mem[1], 1, 1);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL drop_read_data: got %h want %h", obs, e); end
    cmd_if.TX_Busy = 1'b0;
    tick(1);
    send_byte(AA);
    send_byte(8'h01);
    send_byte(8'h7E);
    e = ev(4'h1, 1, 0, 8'h7E, 8'h24, 0, 0);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL write_after_drop: got %h want %h", obs, e); end
  endtask

  task automatic test_reset_mid_frame;
    logic [23:0] e;
    send_byte(AA);
    send_byte(8'h02);
    RST = 1'b0;
    #1;
    e = ev(4'h0, 0, 0, 8'h00, 8'h00, 0, 0);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL midframe_reset: got %h want %h", obs, e); end
    @(posedge CLK); @(posedge CLK); #1;
    RST = 1'b1;
    send_byte(8'h7E);
    tick(1);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL no_stale_strobe: got %h want %h", obs, e); end
    send_byte(AA);
    send_byte(8'h02);
    send_byte(8'h5A);
    e = ev(4'h2, 1, 0, 8'h5A, 8'h00, 0, 0);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL write_after_reset: got %h want %h", obs, e); end
  endtask

  task automatic test_back_to_back;
    logic [23:0] e;
    send_byte(AA);
    send_byte(8'h03);
    send_byte(8'h11);
    send_byte(BB);
    send_byte(8'h03);
    e = ev(4'h3, 0, 1, 8'h11, 8'h00, 0, 1);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL b2b_read_strobe: got %h want %h", obs, e); end
    tick(2);
    e = ev(4'h3, 0, 0, 8'h11, 8'h11, 1, 1);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL b2b_readback: got %h want %h", obs, e); end
    tick(1);
    e = ev(4'h3, 0, 0, 8'h11, 8'h11, 0, 0);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL b2b_tx_accept: got %h want %h", obs, e); end
  endtask

`ifdef REG_CMD_TIMEOUT_EN
  task automatic test_timeout;
    logic [23:0] e;
    send_byte(BB);
    tick(20);
    send_byte(AA);
    send_byte(8'h03);
    send_byte(8'h55);
    e = ev(4'h3, 1, 0, 8'h55, 8'h11, 0, 0);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL timeout_then_write: got %h want %h", obs, e); end
  endtask
`else
  task automatic test_no_timeout;
    logic [23:0] e;
    logic [7:0]  d6;
    d6 = rf_mem[6];
    send_byte(BB);
    tick(30);
    send_byte(8'h06);
    e = ev(4'h6, 0, 1, 8'h11, 8'h11, 0, 1);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL read_after_silence: got %h want %h", obs, e); end
    tick(2);
    e = ev(4'h6, 0, 0, 8'h11, d6, 1, 1);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL silence_readback: got %h want %h", obs, e); end
    tick(1);
  endtask
`endif

  // Reference model: pending-frame byte queue, expected register contents, and a read-age count.
  task automatic test_random;
    logic [7:0]  frame[$];
    logic [7:0]  ref_mem [16];
    logic [7:0]  v, rxb;
    logic        rxv, txb, m_busy;
    int          rd_age;
    logic [3:0]  e_addr;
    logic        e_wr, e_rd, e_txv;
    logic [7:0]  e_wd, e_txd;
    logic [23:0] e;

    RST = 1'b0;
    cmd_if.RX_D_VLD = 1'b0;
    cmd_if.TX_Busy  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      v = 8'($urandom);
      rf_mem[i]  = v;
      ref_mem[i] = v;
    end
    @(posedge CLK); @(posedge CLK); #1;
    RST = 1'b1;
    frame.delete();
    m_busy = 1'b0; rd_age = 0;
    e_addr = 4'h0; e_wr = 1'b0; e_rd = 1'b0; e_wd = 8'h00; e_txd = 8'h00; e_txv = 1'b0;

    for (int cyc = 0; cyc < 800; cyc++) begin
      rxv = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       rxb = AA;
        1:       rxb = BB;
        default: rxb = 8'($urandom);
      endcase
      txb = 1'($urandom_range(0, 1));
      cmd_if.RX_P_DATA = rxb;
      cmd_if.RX_D_VLD  = rxv;
      cmd_if.TX_Busy   = txb;
      @(posedge CLK);
      e_wr = 1'b0;
      e_rd = 1'b0;
      if (m_busy) begin
        if (e_txv && !txb) begin
          m_busy = 1'b0;
          e_txv  = 1'b0;
        end else begin
          rd_age++;
          if (rd_age == 2) begin
            e_txv = 1'b1;
            e_txd = ref_mem[e_addr];
          end
        end
      end else if (rxv) begin
        if (frame.size() == 0) begin
          if (rxb == AA || rxb == BB) frame.push_back(rxb);
        end else begin
          frame.push_back(rxb);
          if (frame.size() == 2) e_addr = rxb[3:0];
          if (frame[0] == BB && frame.size() == 2) begin
            e_rd   = 1'b1;
            m_busy = 1'b1;
            rd_age = 0;
            frame.delete();
          end else if (frame.size() == 3) begin
            e_wr = 1'b1;
            e_wd = rxb;
            ref_mem[e_addr] = rxb;
            frame.delete();
          end
        end
      end
      #1;
      e = ev(e_addr, e_wr, e_rd, e_wd, e_txd, e_txv, m_busy);
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL random[%0d]: got %h want %h (rx_vld=%b byte=%h tx_busy=%b)", cyc, obs, e, rxv, rxb, txb);
      end
    end
    cmd_if.RX_D_VLD = 1'b0;
    cmd_if.TX_Busy  = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    RST         = 1'b0;
    cmd_if.RX_P_DATA = 8'h00;
    cmd_if.RX_D_VLD  = 1'b0;
    cmd_if.TX_Busy   = 1'b0;
    for (int i = 0; i < 16; i++) rf_mem[i] = 8'(i * 29 + 7);

    test_reset;
    test_write;
    test_read;
    test_backpressure;
    test_garbage_drop;
    test_reset_mid_frame;
    test_back_to_back;
`ifdef REG_CMD_TIMEOUT_EN
    test_timeout;
`else
    test_no_timeout;
`endif
    test_random;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_cmd_ctrl.md
# reg_cmd_ctrl

Command controller between the UART receive/transmit path and the register file. Parses byte-wide frames from the RX deserializer into register-file write and read strobes, captures read data returned by the register file, and hands it to the TX serializer through a valid/busy handshake. Sits directly upstream of the register file, driving its Address/WrEn/RdEn/WrData, and consuming its RdData/RdData_Valid.

## Interface
- DATA_WIDTH, 8, width of RX/TX bytes and register data
- ADDR_WIDTH, 4, register-file address width; taken from the LSBs of the address byte
- TIMEOUT_CYCLES, 255, idle-cycle limit inside a partial frame; only used with REG_CMD_TIMEOUT_EN
- CLK  in  1  clock
- RST  in  1  reset, asynchronous, active-low
- RX_P_DATA  in  DATA_WIDTH  received byte, valid when RX_D_VLD is high
- RX_D_VLD  in  1  one-cycle pulse per received byte
- Address  out  ADDR_WIDTH  register-file address
- WrEn  out  1  one-cycle write strobe
- RdEn  out  1  one-cycle read strobe
- WrData  out  DATA_WIDTH  write data
- RdData  in  DATA_WIDTH  register-file read data
- RdData_Valid  in  1  one-cycle pulse qualifying RdData
- TX_P_DATA  out  DATA_WIDTH  byte to transmit
- TX_D_VLD  out  1  transmit request, held until accepted
- TX_Busy  in  1  serializer busy; byte is accepted on a rising edge with TX_D_VLD=1 and TX_Busy=0
- Cmd_Busy  out  1  high in RD_WAIT and TX_SEND; RX bytes are dropped while high

## Operation
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND. All outputs are registered.
- IDLE: a byte of 0xAA moves to WR_ADDR, and 0xBB moves to RD_ADDR. Any other byte is ignored, with no state change.
- WR_ADDR: the next byte is latched as Address (RX_P_DATA[ADDR_WIDTH-1:0]; upper bits ignored), then move to WR_DATA.
- WR_DATA: the next byte is latched into WrData. WrEn pulses for exactly one cycle, then return to IDLE.
- RD_ADDR: the next byte is latched as Address. RdEn pulses for exactly one cycle, then move to RD_WAIT.
- RD_WAIT: on RdData_Valid, capture RdData into TX_P_DATA, set TX_D_VLD, and move to TX_SEND. Wait with no limit until RdData_Valid arrives.
- TX_SEND: hold TX_D_VLD and TX_P_DATA stable. On an edge with TX_Busy=0, clear TX_D_VLD and return to IDLE.
- WrEn and RdEn are never high together. Address holds its last value between frames.
- A byte arriving in RD_WAIT or TX_SEND is discarded. It is not treated as a command byte afterwards.
- A command byte (0xAA/0xBB) received in WR_ADDR, WR_DATA or RD_ADDR is treated as data, not as a resync.

## Timing
- Reset values: Address=0, WrEn=0, RdEn=0, WrData=0, TX_P_DATA=0, TX_D_VLD=0, Cmd_Busy=0, state IDLE.
- Reset asserted mid-frame abandons the frame. No strobe is issued after release.
- Write: the data byte is sampled at edge N. WrEn, Address and WrData are valid during cycle N..N+1, and the register file writes at edge N+1.
- Read: the address byte is sampled at edge N, and RdEn is high during cycle N..N+1. The register file returns RdData_Valid after edge N+1. The controller captures at edge N+2, and TX_D_VLD is high from edge N+2.
- Minimum spacing between frames is one cycle. IDLE accepts a new command byte on the edge after WrEn is issued, or after TX acceptance.
- Back-to-back RX_D_VLD pulses on consecutive cycles are all accepted in the parse states.

## Configuration
- REG_CMD_TIMEOUT_EN defined:
  - A counter runs in WR_ADDR, WR_DATA and RD_ADDR. It clears on every accepted byte and on state entry.
  - When it reaches TIMEOUT_CYCLES with no byte received, the FSM returns to IDLE with no strobe.
  - The counter width is the minimum needed to hold TIMEOUT_CYCLES.
- REG_CMD_TIMEOUT_EN undefined: no counter exists, and parse states wait indefinitely.

## Test plan
- Write: bytes 0xAA, 0x05, 0x3C → one WrEn pulse with Address=5 and WrData=0x3C. RdEn stays 0.
- Read: after the write, bytes 0xBB, 0x05 → RdEn pulse, then TX_P_DATA=0x3C with TX_D_VLD high two edges after the address byte.
- TX backpressure: TX_Busy=1 for 10 cycles during TX_SEND → TX_D_VLD and TX_P_DATA=0x3C held stable. Accepted on the first edge with TX_Busy=0, then IDLE.
- Garbage and drop: byte 0x12 in IDLE → no strobe. A byte sent while Cmd_Busy=1 → ignored, and the next frame 0xAA, 0x01, 0x7E writes correctly.
- Reset mid-frame: 0xAA, 0x02, then RST low for 2 cycles → all outputs 0, no WrEn. The next frame parses from IDLE.
- Timeout (REG_CMD_TIMEOUT_EN, TIMEOUT_CYCLES=20): 0xBB, then silence for 20 cycles → back to IDLE with no RdEn. Then 0xAA, 0x03, 0x55 writes reg 3.
